mod_fetch_sequencer: RTL and testbench

Fetch-stage controller that owns the program counter register and drives the PC mux (`mux_control`, `pc_plus_4` out; `next_address` back). It issues one instruction-memory request per cycle, captures the returned word into the IF/ID output register, and holds that register under decode stall. On a taken branch it squashes the wrong-path instruction and redirects fetch.

---
 rtl/mod_fetch_sequencer_pkg.sv | 18 +
 rtl/mod_fetch_sequencer_if.sv | 24 ++
 rtl/mod_pc_mux.sv | 19 +
 rtl/mod_fetch_sequencer.sv | 91 +++++++++
 tb/tb_mod_fetch_sequencer.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/mod_fetch_sequencer_pkg.sv
// Shared constants and types for the fetch stage: widths, PC increment,
// reset vector default and the fetch FSM state encoding.
package mod_fetch_sequencer_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_INCR              = 32'd4;
    // Instruction addresses are word aligned; low two bits are forced to zero.
    localparam logic [ADDR_W-1:0] ADDR_WORD_MASK       = 32'hFFFF_FFFC;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/mod_fetch_sequencer_if.sv
// Instruction-memory request channel between the fetch sequencer (master)
// and the instruction memory (slave). No request is ever left outstanding.
interface mod_fetch_sequencer_if;

    logic                                        imem_req;
    logic [mod_fetch_sequencer_pkg::ADDR_W-1:0]  imem_addr;
    logic                                        imem_ack;
    logic [mod_fetch_sequencer_pkg::DATA_W-1:0]  imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/mod_pc_mux.sv
// PC source mux: selects the branch target when mux_control is high,
// otherwise the sequential address pc_plus_4.
module mod_pc_mux
    import mod_fetch_sequencer_pkg::*;
(
    input  logic              mux_control,
    input  logic [ADDR_W-1:0] pc_plus_4,
    input  logic [ADDR_W-1:0] branch_address,
    output logic [ADDR_W-1:0] next_address
);

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_bit
            assign next_address[gi] = mux_control ? branch_address[gi] : pc_plus_4[gi];
        end
    endgenerate

endmodule

// File: rtl/mod_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one instruction request per
// cycle, holds the IF/ID register under stall and squashes on taken branch.
module mod_fetch_sequencer
    import mod_fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_taken,
    output logic                 mux_control,
    output logic [ADDR_W-1:0]    pc_plus_4,
    input  logic [ADDR_W-1:0]    next_address,
    mod_fetch_sequencer_if.master imem,
    output logic                 if_valid,
    output logic [DATA_W-1:0]    if_instr,
    output logic [ADDR_W-1:0]    if_pc,
    output logic [31:0]          fetch_count
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              if_valid_reg, if_valid_next;
    logic [DATA_W-1:0] if_instr_reg, if_instr_next;
    logic [ADDR_W-1:0] if_pc_reg, if_pc_next;
    logic [31:0]       fetch_count_reg, fetch_count_next;
    logic              req;
    logic              fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_VECTOR;
            if_valid_reg    <= 1'b0;
            if_instr_reg    <= '0;
            if_pc_reg       <= '0;
            fetch_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            if_valid_reg    <= if_valid_next;
            if_instr_reg    <= if_instr_next;
            if_pc_reg       <= if_pc_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        if_valid_next    = if_valid_reg;
        if_instr_next    = if_instr_reg;
        if_pc_next       = if_pc_reg;
        fetch_count_next = fetch_count_reg;

        // A held instruction under stall blocks new requests so it is not overwritten.
        req  = (state_reg == ST_RUN) && !branch_taken && !(if_valid_reg && stall);
        fire = req && imem.imem_ack;

        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase

        if (branch_taken) begin
            // Squash wins over stall: the wrong-path instruction is dropped.
            pc_next       = next_address & ADDR_WORD_MASK;
            if_valid_next = 1'b0;
        end else if (fire) begin
            if_instr_next    = imem.imem_rdata;
            if_pc_next       = pc_reg;
            if_valid_next    = 1'b1;
            pc_next          = next_address & ADDR_WORD_MASK;
            fetch_count_next = fetch_count_reg + 32'd1;
        end else if (if_valid_reg && !stall) begin
            if_valid_next = 1'b0;
        end
    end

    assign mux_control    = branch_taken;
    assign pc_plus_4      = pc_reg + PC_INCR;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;
    assign if_valid       = if_valid_reg;
    assign if_instr       = if_instr_reg;
    assign if_pc          = if_pc_reg;
    assign fetch_count    = fetch_count_reg;

endmodule

// File: tb/tb_mod_fetch_sequencer.sv
// Directed bench for the fetch sequencer with the PC mux looped back;
// instruction memory returns the bitwise inverse of the fetch address.
module tb_mod_fetch_sequencer;
    import mod_fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic        ack = 1'b1;
    logic        mux_control;
    logic [31:0] pc_plus_4;
    logic [31:0] next_address;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    int tests_run = 0;
    int tests_failed = 0;

    mod_fetch_sequencer_if imem ();

    assign imem.imem_ack   = ack;
    assign imem.imem_rdata = ~imem.imem_addr;

    mod_fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .mux_control  (mux_control),
        .pc_plus_4    (pc_plus_4),
        .next_address (next_address),
        .imem         (imem.master),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .fetch_count  (fetch_count)
    );

    mod_pc_mux u_pc_mux (
        .mux_control    (mux_control),
        .pc_plus_4      (pc_plus_4),
        .branch_address (branch_address),
        .next_address   (next_address)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string t, input logic req, input logic [31:0] addr,
                       input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] cnt);
        chk({t, ".imem_req"},    {31'b0, imem.imem_req}, {31'b0, req});
        chk({t, ".imem_addr"},   imem.imem_addr,         addr);
        chk({t, ".if_valid"},    {31'b0, if_valid},      {31'b0, v});
        chk({t, ".if_pc"},       if_pc,                  pc);
        chk({t, ".if_instr"},    if_instr,               instr);
        chk({t, ".fetch_count"}, fetch_count,            cnt);
        $display("[TB] %s: req=%0b addr=%h valid=%0b if_pc=%h instr=%h count=%0d",
                 t, imem.imem_req, imem.imem_addr, if_valid, if_pc, if_instr, fetch_count);
    endtask

    initial begin
        step(); step();
        cyc("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
        chk("reset.mux_control", {31'b0, mux_control}, 32'd0);

        rst_n = 1'b1; #1;
        cyc("boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
        step(); cyc("c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
        step(); cyc("c2", 1'b1, 32'h4, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'd1);
        step(); cyc("c3", 1'b1, 32'h8, 1'b1, 32'h4, 32'hFFFF_FFFB, 32'd2);

        // Stall two cycles while if_pc = 0x8.
        step(); stall = 1'b1; #1;
        cyc("stall0", 1'b0, 32'hC, 1'b1, 32'h8, 32'hFFFF_FFF7, 32'd3);
        step(); cyc("stall1", 1'b0, 32'hC, 1'b1, 32'h8, 32'hFFFF_FFF7, 32'd3);
        step(); stall = 1'b0; #1;
        cyc("release", 1'b1, 32'hC, 1'b1, 32'h8, 32'hFFFF_FFF7, 32'd3);

        // No ack for three cycles at pc 0x10.
        step(); ack = 1'b0; #1;
        cyc("noack0", 1'b1, 32'h10, 1'b1, 32'hC, 32'hFFFF_FFF3, 32'd4);
        step(); cyc("noack1", 1'b1, 32'h10, 1'b0, 32'hC, 32'hFFFF_FFF3, 32'd4);
        step(); cyc("noack2", 1'b1, 32'h10, 1'b0, 32'hC, 32'hFFFF_FFF3, 32'd4);
        step(); ack = 1'b1; #1;
        cyc("ack", 1'b1, 32'h10, 1'b0, 32'hC, 32'hFFFF_FFF3, 32'd4);

        // Branch to 0x100 together with stall and ack.
        step(); stall = 1'b1; branch_taken = 1'b1; branch_address = 32'h100; #1;
        cyc("branch", 1'b0, 32'h14, 1'b1, 32'h10, 32'hFFFF_FFEF, 32'd5);
        chk("branch.mux_control", {31'b0, mux_control}, 32'd1);
        chk("branch.next_address", next_address, 32'h100);
        step(); stall = 1'b0; branch_taken = 1'b0; #1;
        cyc("branch+1", 1'b1, 32'h100, 1'b0, 32'h10, 32'hFFFF_FFEF, 32'd5);
        chk("branch+1.mux_control", {31'b0, mux_control}, 32'd0);

        // Wrap at top of address space.
        step(); branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC; #1;
        cyc("br_top", 1'b0, 32'h104, 1'b1, 32'h100, 32'hFFFF_FEFF, 32'd6);
        step(); branch_taken = 1'b0; #1;
        cyc("top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100, 32'hFFFF_FEFF, 32'd6);
        chk("top.pc_plus_4", pc_plus_4, 32'h0);
        step(); branch_taken = 1'b1; branch_address = 32'h103; #1;
        cyc("wrapped", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h3, 32'd7);
        step(); branch_taken = 1'b0; #1;
        cyc("misalign", 1'b1, 32'h100, 1'b0, 32'hFFFF_FFFC, 32'h3, 32'd7);
        step(); cyc("misalign+1", 1'b1, 32'h104, 1'b1, 32'h100, 32'hFFFF_FEFF, 32'd8);

        // Asynchronous reset mid-stream.
        rst_n = 1'b0; #1;
        cyc("arst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
        chk("arst.mux_control", {31'b0, mux_control}, 32'd0);
        step(); step();
        rst_n = 1'b1; #1;
        cyc("reboot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
        step(); cyc("r1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
        step(); cyc("r2", 1'b1, 32'h4, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'd1);
        step(); cyc("r3", 1'b1, 32'h8, 1'b1, 32'h4, 32'hFFFF_FFFB, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
